// File: rtl/plan_pkg.sv
// Shared types and constants for the PLAN sigmoid/tanh pipeline.
// Thresholds and offsets are expressed as functions of the fractional width.
package plan_pkg;

  typedef enum logic [1:0] {
    SEG0    = 2'd0,
    SEG1    = 2'd1,
    SEG2    = 2'd2,
    SEG_SAT = 2'd3
  } plan_seg_e;

  localparam logic MODE_SIGMOID = 1'b0;
  localparam logic MODE_TANH    = 1'b1;

  // idx 0: 1.0, idx 1: 2.375, idx 2: 5.0
  function automatic int unsigned plan_thr(input int unsigned frac_w, input int unsigned idx);
    int unsigned r;
    case (idx)
      32'd0:   r = 32'd1 << frac_w;
      32'd1:   r = 32'd19 << (frac_w - 32'd3);
      default: r = 32'd5 << frac_w;
    endcase
    return r;
  endfunction

  // idx 0: 0.5, idx 1: 0.625, idx 2: 0.84375
  function automatic int unsigned plan_off(input int unsigned frac_w, input int unsigned idx);
    int unsigned r;
    case (idx)
      32'd0:   r = 32'd1 << (frac_w - 32'd1);
      32'd1:   r = 32'd5 << (frac_w - 32'd3);
      default: r = 32'd27 << (frac_w - 32'd5);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/plan_seg_eval.sv
// Stage-2 datapath: picks the PLAN segment for a non-negative operand and
// evaluates its shift-add line; saturated inputs yield exactly 1.0.
module plan_seg_eval
  import plan_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10
) (
  input  logic [DATA_W-1:0] xp_i,
  output logic [DATA_W-1:0] y_c_o,
  output plan_seg_e         seg_c_o
);

  localparam logic [DATA_W-1:0] ONE  = DATA_W'(plan_thr(FRAC_W, 0));
  localparam logic [DATA_W-1:0] T1   = DATA_W'(plan_thr(FRAC_W, 0));
  localparam logic [DATA_W-1:0] T2   = DATA_W'(plan_thr(FRAC_W, 1));
  localparam logic [DATA_W-1:0] T3   = DATA_W'(plan_thr(FRAC_W, 2));
  localparam logic [DATA_W-1:0] OFF0 = DATA_W'(plan_off(FRAC_W, 0));
  localparam logic [DATA_W-1:0] OFF1 = DATA_W'(plan_off(FRAC_W, 1));
  localparam logic [DATA_W-1:0] OFF2 = DATA_W'(plan_off(FRAC_W, 2));

  always_comb begin
    seg_c_o = SEG_SAT;
    y_c_o   = ONE;
    if (xp_i < T1) begin
      seg_c_o = SEG0;
      y_c_o   = (xp_i >> 2) + OFF0;
    end else if (xp_i < T2) begin
      seg_c_o = SEG1;
      y_c_o   = (xp_i >> 3) + OFF1;
    end else if (xp_i < T3) begin
      seg_c_o = SEG2;
      y_c_o   = (xp_i >> 5) + OFF2;
    end
  end

endmodule

// File: rtl/plan_sigmoid_pipe.sv
// Three-stage PLAN sigmoid/tanh pipeline with valid/ready on both sides and a
// single global stall; stage 2 arithmetic lives in plan_seg_eval.
module plan_sigmoid_pipe
  import plan_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] f_x,
  output logic              sat
);

  if (FRAC_W < 5 || DATA_W < FRAC_W + 4) begin : g_bad_params
    $error("plan_sigmoid_pipe: need FRAC_W >= 5 and DATA_W - FRAC_W >= 4");
  end

  localparam logic [DATA_W-1:0] ONE = DATA_W'(plan_thr(FRAC_W, 0));
  localparam logic [DATA_W-1:0] T3  = DATA_W'(plan_thr(FRAC_W, 2));

  logic en_c;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_xp_q,    s1_xp_d;
  logic              s1_neg_q,   s1_neg_d;
  logic              s1_mode_q,  s1_mode_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_y_q,     s2_y_d;
  logic              s2_neg_q,   s2_neg_d;
  logic              s2_mode_q,  s2_mode_d;
  logic              s2_sat_q,   s2_sat_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] f_x_q,       f_x_d;
  logic              sat_q,       sat_d;

  logic [DATA_W-1:0] a_c;
  logic [DATA_W:0]   two_a_c;
  logic [DATA_W-1:0] xp_c;
  logic [DATA_W-1:0] y_c;
  plan_seg_e         seg_c;
  logic [DATA_W-1:0] t_c;
  logic [DATA_W-1:0] f_c;

  // Whole pipe advances unless a result is waiting on a stalled consumer.
  assign en_c     = !out_valid_q || out_ready;
  assign in_ready = en_c;

  // Stage 1: magnitude (most-negative input maps to 2^(DATA_W-1)), tanh pre-scale.
  always_comb begin
    a_c     = x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
    two_a_c = {a_c, 1'b0};
    xp_c    = a_c;
    if (mode == MODE_TANH) begin
      xp_c = (two_a_c >= {1'b0, T3}) ? T3 : two_a_c[DATA_W-1:0];
    end
  end

  plan_seg_eval #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_seg_eval (
    .xp_i    (s1_xp_q),
    .y_c_o   (y_c),
    .seg_c_o (seg_c)
  );

  // Stage 3: fold the sign back in; tanh(x) = 2*sigmoid(2x) - 1.
  always_comb begin
    t_c = (s2_y_q << 1) - ONE;
    if (s2_mode_q == MODE_TANH) begin
      f_c = s2_neg_q ? (~t_c + DATA_W'(1)) : t_c;
    end else begin
      f_c = s2_neg_q ? (ONE - s2_y_q) : s2_y_q;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_xp_d     = s1_xp_q;
    s1_neg_d    = s1_neg_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_y_d      = s2_y_q;
    s2_neg_d    = s2_neg_q;
    s2_mode_d   = s2_mode_q;
    s2_sat_d    = s2_sat_q;
    out_valid_d = out_valid_q;
    f_x_d       = f_x_q;
    sat_d       = sat_q;
    if (en_c) begin
      s1_valid_d  = in_valid;
      if (in_valid) begin
        s1_xp_d   = xp_c;
        s1_neg_d  = x[DATA_W-1];
        s1_mode_d = mode;
      end
      s2_valid_d  = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d    = y_c;
        s2_neg_d  = s1_neg_q;
        s2_mode_d = s1_mode_q;
        s2_sat_d  = (seg_c == SEG_SAT);
      end
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        f_x_d = f_c;
        sat_d = s2_sat_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_xp_q     <= '0;
      s1_neg_q    <= 1'b0;
      s1_mode_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      s2_neg_q    <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      f_x_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_xp_q     <= s1_xp_d;
      s1_neg_q    <= s1_neg_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_y_q      <= s2_y_d;
      s2_neg_q    <= s2_neg_d;
      s2_mode_q   <= s2_mode_d;
      s2_sat_q    <= s2_sat_d;
      out_valid_q <= out_valid_d;
      f_x_q       <= f_x_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f_x       = f_x_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_plan_sigmoid_pipe.sv
// Directed bench for plan_sigmoid_pipe: point vectors, streaming vs a reference
// model, backpressure, mid-stream reset and a 12/6 parameter corner.
module tb_plan_sigmoid_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, mode, out_valid, out_ready, sat;
  logic [15:0] x, f_x;
  logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, sat2;
  logic [11:0] x2, f_x2;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  real max_err  = 0.0;

  typedef struct {
    int          xi;
    bit          m;
    logic [15:0] f;
    bit          s;
  } exp_t;

  always #5 clk = ~clk;

  plan_sigmoid_pipe #(.DATA_W(16), .FRAC_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .f_x(f_x), .sat(sat)
  );

  plan_sigmoid_pipe #(.DATA_W(12), .FRAC_W(6)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x2), .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
    .f_x(f_x2), .sat(sat2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Integer reference of the PLAN equations, Q6.10.
  function automatic exp_t ref_model(input int xi, input bit m);
    exp_t e;
    int one, a, xp, y, t, f;
    one = 1024;
    a   = (xi < 0) ? -xi : xi;
    xp  = m ? ((2 * a < 5 * one) ? 2 * a : 5 * one) : a;
    e.s = 1'b0;
    if (xp < one)                 y = xp / 4 + one / 2;
    else if (xp < (19 * one) / 8) y = xp / 8 + (5 * one) / 8;
    else if (xp < 5 * one)        y = xp / 32 + (27 * one) / 32;
    else begin y = one; e.s = 1'b1; end
    if (!m) f = (xi < 0) ? one - y : y;
    else begin
      t = 2 * y - one;
      f = (xi < 0) ? -t : t;
    end
    e.xi = xi;
    e.m  = m;
    e.f  = 16'(f);
    return e;
  endfunction

  task automatic single(input string tag, input logic [15:0] xv, input logic mv,
                        input logic [15:0] ef, input logic es);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = xv;
    mode      = mv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_f"},   32'(f_x), 32'(ef));
    check({tag, "_sat"}, 32'(sat), 32'(es));
    @(negedge clk);
  endtask

  task automatic single2(input string tag, input logic [11:0] xv, input logic [11:0] ef);
    int lat;
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    x2         = xv;
    mode2      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_f"},   32'(f_x2), 32'(ef));
    @(negedge clk);
  endtask

  // Streams n samples x = start + i*step_milli/1000 with alternating mode,
  // optionally dropping out_ready for stall_len cycles from cycle stall_at.
  task automatic stream(input string tag, input int n, input int start, input int step_milli,
                        input int stall_at, input int stall_len);
    exp_t        q[$];
    exp_t        e;
    int          sent, got, cyc, first_acc, first_out, xi;
    logic [15:0] held;
    bit          stalled;
    real         tv, gv, err;
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1; held = '0;
    while (got < n && cyc < n * 3 + 50) begin
      stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalled;
      in_valid  = (sent < n);
      xi        = start + (sent * step_milli) / 1000;
      x         = 16'(xi);
      mode      = sent[0];
      #1;
      if (stalled && out_valid) begin
        if (cyc == stall_at) held = f_x;
        else check({tag, "_stall_hold"}, 32'(f_x), 32'(held));
        check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        if (q.size() == 0) begin
          check({tag, "_spurious"}, 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check({tag, "_data"}, 32'({sat, f_x}), 32'({e.s, e.f}));
          if (!e.m) begin
            tv  = 1.0 / (1.0 + $exp(-real'(e.xi) / 1024.0));
            gv  = real'($signed(f_x)) / 1024.0;
            err = (gv > tv) ? gv - tv : tv - gv;
            if (err > max_err) max_err = err;
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back(ref_model(xi, sent[0]));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"},   32'(got), 32'(n));
    check({tag, "_latency"}, 32'(first_out - first_acc), 32'd3);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0; x  = '0; mode  = 1'b0; out_ready  = 1'b1;
    in_valid2  = 1'b0; x2 = '0; mode2 = 1'b0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f_x",       32'(f_x),       32'd0);
    check("rst_sat",       32'(sat),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;
    @(negedge clk);

    single("sig_0",     16'sd0,      1'b0, 16'd512,  1'b0);
    single("sig_p1",    16'sd1024,   1'b0, 16'd768,  1'b0);
    single("sig_m1",    -16'sd1024,  1'b0, 16'd256,  1'b0);
    single("sig_p4",    16'sd4096,   1'b0, 16'd992,  1'b0);
    single("sig_sat",   16'sd6000,   1'b0, 16'd1024, 1'b1);
    single("sig_min",   16'h8000,    1'b0, 16'd0,    1'b1);
    single("tanh_p05",  16'sd512,    1'b1, 16'd512,  1'b0);
    single("tanh_m05",  -16'sd512,   1'b1, 16'hFE00, 1'b0);
    single("tanh_sat",  16'sd3000,   1'b1, 16'd1024, 1'b1);
    single("tanh_0",    16'sd0,      1'b1, 16'd0,    1'b0);

    stream("sweep", 1001, -8192, 16384, 1 << 30, 0);
    check("sweep_max_err", 32'(max_err <= 0.02), 32'd1);

    stream("bp", 30, -1500, 100000, 10, 5);

    // Three samples in flight, then an asynchronous reset between edges.
    out_ready = 1'b1;
    in_valid  = 1'b1; mode = 1'b0;
    x = 16'sd1024; @(posedge clk); @(negedge clk);
    x = 16'sd4096; @(posedge clk); @(negedge clk);
    x = -16'sd1024; @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_f_x",   32'(f_x),       32'd768);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_f_x",       32'(f_x),       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    single("post_rst", 16'sd512, 1'b0, 16'd640, 1'b0);

    single2("w12_p1", 12'sd64,  12'd48);
    single2("w12_m1", -12'sd64, 12'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/plan_sigmoid_pipe.md
# plan_sigmoid_pipe

Parametrised, pipelined successor to the combinational PLAN sigmoid. It evaluates the piecewise-linear sigmoid approximation on signed fixed-point input and can also produce tanh through a per-sample mode bit. The block has a 3-stage pipeline with valid/ready handshakes on both sides. It sits between activation producers (MAC/accumulator outputs) and downstream neuron buffers.

## Interface
- DATA_W, 16: input/output word width, two's complement.
- FRAC_W, 10: fractional bits.
  - Legal range: FRAC_W ≥ 5 and DATA_W − FRAC_W ≥ 4 (elaboration-time assertion).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all pipeline state.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample this cycle.
- x  in  DATA_W  signed input, Q(DATA_W−FRAC_W).FRAC_W.
- mode  in  1  0 = sigmoid, 1 = tanh; captured with x.
- out_valid  out  1  f_x holds a result.
- out_ready  in  1  downstream accepts f_x this cycle.
- f_x  out  DATA_W  signed result, same Q format.
  - Sigmoid range: 0..1.0.
  - Tanh range: −1.0..+1.0.
- sat  out  1  the sample fell in the saturation segment (|x'| ≥ 5.0).

## Operation
- Constants, with ONE = 1<<FRAC_W:
  - T1 = ONE
  - T2 = 19<<(FRAC_W−3) (2.375)
  - T3 = 5<<FRAC_W
  - OFF0 = ONE>>1
  - OFF1 = 5<<(FRAC_W−3)
  - OFF2 = 27<<(FRAC_W−5)
- Stage 1: compute a = |x| as an unsigned DATA_W value; −2^(DATA_W−1) maps to 2^(DATA_W−1) with no overflow.
  - In tanh mode, x' = min(2a, T3); otherwise x' = a.
  - Register x', neg = x[MSB], and mode.
- Stage 2: segment select and shift-add. All shifts are logical right shifts that truncate.
  - x' < T1: y = (x'>>2) + OFF0
  - T1 ≤ x' < T2: y = (x'>>3) + OFF1
  - T2 ≤ x' < T3: y = (x'>>5) + OFF2
  - x' ≥ T3: y = ONE, and sat = 1
- Stage 3: symmetry and mode mapping.
  - Sigmoid: f_x = neg ? ONE − y : y.
  - Tanh: t = 2y − ONE, then f_x = neg ? −t : t.
  - x = 0 takes the positive path.
- Results are never negative-zero corrected or rounded beyond the truncation above. The outputs are bit-exact to these equations.

## Timing
- Global stall: en = !out_valid || out_ready. All three stages advance together when en = 1.
- in_ready = en, combinational. A transfer occurs when in_valid && in_ready.
- Latency: a sample accepted at edge N appears with out_valid = 1 after edge N+3, provided en stayed high.
- Throughput: 1 sample/cycle with no backpressure.
- Bubbles are carried; they are not compacted.
- While out_valid && !out_ready:
  - f_x, sat, and all stage registers hold.
  - in_ready = 0.
- An output beat completes on out_valid && out_ready. A new input can enter on the same edge (simultaneous accept and drain).
- Reset values:
  - out_valid = 0, f_x = 0, sat = 0.
  - All internal valids = 0.
  - in_ready = 1 (follows from out_valid = 0).
- Reset asserted mid-operation discards every in-flight sample immediately and asynchronously. No partial result is emitted after release.

## Structure
- plan_pkg holds:
  - typedef plan_seg_e {SEG0, SEG1, SEG2, SEG_SAT}
  - constant functions plan_thr(FRAC_W, idx) and plan_off(FRAC_W, idx), which return the T*/OFF* values above
  - localparam MODE_SIGMOID = 1'b0, MODE_TANH = 1'b1
- One sub-module, plan_seg_eval: combinational stage-2 datapath (segment compare plus shift-add).
  - Parameterised by DATA_W and FRAC_W.
  - Outputs y and seg.
  - Instantiated once in plan_sigmoid_pipe, which owns the registers, handshake, and stages 1 and 3.

## Test plan
Default parameters (16/10), out_ready = 1 unless stated.
- Sigmoid sweep, inputs and expected f_x:
  - x = 0 → 512
  - x = 1024 → 768
  - x = −1024 → 256
  - x = 4096 → 992
  - x = 6000 → 1024 with sat = 1
  - x = −32768 → 0 with sat = 1
- Tanh mode:
  - x = 512 → 512
  - x = −512 → −512 (0xFE00)
  - x = 3000 → 1024 with sat = 1
  - x = 0 → 0
- Streaming: 1001 back-to-back samples, −8.0 to +8.0 in steps of 0.016, mode alternating.
  - out_valid first rises 3 cycles after the first accept.
  - Results are in order and match the reference model bit-exactly.
  - Max |error| vs. true sigmoid ≤ 0.02.
- Backpressure: drop out_ready for 5 cycles mid-stream.
  - in_ready = 0 during the stall.
  - f_x is stable during the stall.
  - No sample is lost or duplicated once out_ready returns.
- Reset mid-stream: assert reset with 3 samples in flight.
  - out_valid = 0 and f_x = 0 immediately.
  - After release, the first output corresponds to the first post-reset input.
- Parameter corner: DATA_W = 12, FRAC_W = 6.
  - x = 64 → 48
  - x = −64 → 16
